// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
package uart_pkg;

   localparam int unsigned MAX_DATA_W = 16;
   localparam logic        TX_IDLE    = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP1,
      STOP2
   } tx_state_e;

   typedef struct packed {
      logic parity_en;
      logic parity_odd;
      logic stop2;
   } line_cfg_t;

   // Even parity of data, inverted when odd parity is selected.
   function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: loads max(div,1)-1 on load, flags the last cycle of a bit.
module uart_bit_timer #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   output logic             tc_c
);

   logic [DIV_W-1:0] cnt_q;

   // A divisor of 0 behaves like 1: both load a count of 0.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= (div == '0) ? '0 : div - DIV_W'(1);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - DIV_W'(1);
      end
   end

   assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART Tx line between NREQ byte requesters.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DIV_W  = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESETn,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*DATA_W-1:0]    req_data,
   output logic [NREQ-1:0]           req_ready,
   input  logic [DIV_W-1:0]          baud_div,
   input  logic                      parity_en,
   input  logic                      parity_odd,
   input  logic                      stop2,
   output logic                      tx,
   output logic                      busy,
   output logic [$clog2(NREQ)-1:0]   grant_id,
   output logic                      frame_done
);

   localparam int unsigned ID_W  = $clog2(NREQ);
   localparam int unsigned SUM_W = ID_W + 1;
   localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   tx_state_e         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] data_q, data_d;
   line_cfg_t         cfg_q, cfg_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [ID_W-1:0]   rr_q, rr_d;
   logic [ID_W-1:0]   gid_d;
   logic              run_q;
   logic              tx_d, busy_d;
   logic              tc, load, last_stop, found, grant;
   logic [DIV_W-1:0]  load_div;
   logic [ID_W-1:0]   win;
   logic [SUM_W-1:0]  sum;
   logic [DATA_W-1:0] req_bytes [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
   end

   uart_bit_timer #(.DIV_W(DIV_W)) u_timer (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .load    (load),
      .div     (load_div),
      .tc_c    (tc)
   );

   assign last_stop  = tc && ((state_q == STOP2) || ((state_q == STOP1) && !cfg_q.stop2));
   assign frame_done = last_stop;

   // Next-state, arbitration and line-value logic.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      data_d    = data_q;
      cfg_d     = cfg_q;
      div_d     = div_q;
      bit_d     = bit_q;
      rr_d      = rr_q;
      gid_d     = grant_id;
      found     = 1'b0;
      win       = '0;
      sum       = '0;
      grant     = 1'b0;
      req_ready = '0;
      tx_d      = TX_IDLE;

      // First valid requester at or after the RR pointer, wrapping.
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, rr_q} + SUM_W'(k);
         if (sum >= SUM_W'(NREQ)) sum = sum - SUM_W'(NREQ);
         if (!found && req_valid[sum[ID_W-1:0]]) begin
            found = 1'b1;
            win   = sum[ID_W-1:0];
         end
      end
      grant = found && run_q && ((state_q == IDLE) || last_stop);

      case (state_q)
         IDLE:   ;
         START:  if (tc) begin
                    state_d = DATA;
                    bit_d   = '0;
                 end
         DATA:   if (tc) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_W - 1)) state_d = cfg_q.parity_en ? PARITY : STOP1;
                    else bit_d = bit_q + BIT_W'(1);
                 end
         PARITY: if (tc) state_d = STOP1;
         STOP1:  if (tc) state_d = cfg_q.stop2 ? STOP2 : IDLE;
         STOP2:  if (tc) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (grant) begin
         state_d          = START;
         shift_d          = req_bytes[win];
         data_d           = req_bytes[win];
         cfg_d.parity_en  = parity_en;
         cfg_d.parity_odd = parity_odd;
         cfg_d.stop2      = stop2;
         div_d            = baud_div;
         gid_d            = win;
         rr_d             = (win == ID_W'(NREQ - 1)) ? '0 : win + ID_W'(1);
         req_ready        = NREQ'(1) << win;
      end

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = calc_parity(MAX_DATA_W'(data_d), cfg_d.parity_odd);
         default: tx_d = TX_IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   assign load     = grant || ((state_q != IDLE) && tc);
   assign load_div = grant ? baud_div : div_q;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         data_q   <= '0;
         cfg_q    <= '0;
         div_q    <= '0;
         bit_q    <= '0;
         rr_q     <= '0;
         grant_id <= '0;
         run_q    <= 1'b0;
         tx       <= TX_IDLE;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         data_q   <= data_d;
         cfg_q    <= cfg_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         rr_q     <= rr_d;
         grant_id <= gid_d;
         run_q    <= 1'b1;
         tx       <= tx_d;
         busy     <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: stimulus queues expected frames, a monitor checks the line.
module tb_uart_tx_sched;

   localparam int unsigned NREQ = 4;

   typedef struct {
      logic [1:0]  id;
      logic [7:0]  data;
      logic        pen;
      logic        s2;
      logic        par;
      logic        b2b;
      logic [15:0] div;
   } exp_t;

   logic             PCLK;
   logic             PRESETn;
   logic [NREQ-1:0]  req_valid;
   logic [NREQ*8-1:0] req_data;
   logic [NREQ-1:0]  req_ready;
   logic [15:0]      baud_div;
   logic             parity_en, parity_odd, stop2;
   logic             tx, busy, frame_done;
   logic [1:0]       grant_id;

   exp_t       exp_q [$];
   logic [7:0] reqq [NREQ][$];
   logic [3:0] acc;
   int         n_chk = 0;
   int         n_pass = 0;
   int         cyc = 0;
   int         last_done = 0;

   uart_tx_sched #(.NREQ(NREQ), .DATA_W(8), .DIV_W(16)) dut (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .baud_div   (baud_div),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .stop2      (stop2),
      .tx         (tx),
      .busy       (busy),
      .grant_id   (grant_id),
      .frame_done (frame_done)
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   initial forever begin
      @(posedge PCLK);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_chk);
      $fatal(1);
   end

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, expv, $time);
   endfunction

   // Requester model: holds each byte valid until its ready strobe is seen.
   initial forever begin
      @(negedge PCLK);
      acc = req_ready;
   end

   initial begin
      logic [1:0] ii;
      logic [3:0] vld;
      logic [7:0] cur [NREQ];
      req_valid = '0;
      req_data  = '0;
      forever begin
         @(posedge PCLK);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            ii = 2'(i);
            if (acc[ii] && reqq[ii].size() > 0) void'(reqq[ii].pop_front());
         end
         for (int i = 0; i < NREQ; i++) begin
            ii = 2'(i);
            vld[ii] = (reqq[ii].size() > 0);
            cur[ii] = vld[ii] ? reqq[ii][0] : 8'h00;
         end
         req_valid = vld;
         req_data  = {cur[3], cur[2], cur[1], cur[0]};
      end
   end

   task automatic check_frame();
      exp_t       e;
      int         eff;
      int         nb;
      logic [11:0] bits;
      logic [3:0] bi;
      logic       last;
      if (exp_q.size() == 0) begin
         chk("unexpected_grant", 32'(req_ready), 32'(0));
         @(negedge PCLK);
         return;
      end
      e = exp_q.pop_front();
      chk("grant_onehot", 32'(req_ready), 32'(1) << e.id);
      if (e.b2b) chk("b2b_gap", 32'(cyc - last_done), 32'(0));
      eff  = (e.div == 16'd0) ? 1 : int'(e.div);
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bi = 4'(i + 1);
         bits[bi] = e.data[3'(i)];
      end
      nb = 10;
      if (e.pen) begin
         bits[9] = e.par;
         nb = 11;
      end
      if (e.s2) nb = nb + 1;
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c < eff; c++) begin
            @(negedge PCLK);
            if (!PRESETn) return;
            last = (b == nb - 1) && (c == eff - 1);
            if (b == 0 && c == 0) chk("grant_id", 32'(grant_id), 32'(e.id));
            bi = 4'(b);
            chk("frame_bit", 32'({tx, busy, frame_done, last ? 1'b0 : (req_ready != 4'b0)}),
                32'({bits[bi], 1'b1, last, 1'b0}));
            if (last) last_done = cyc;
         end
      end
   endtask

   // Monitor: idle line when nothing is granted, full frame check after each grant.
   initial forever begin
      @(negedge PCLK);
      if (req_ready == 4'b0) chk("idle_line", 32'({tx, busy, frame_done}), 32'(3'b100));
      while (PRESETn && req_ready != 4'b0) check_frame();
   end

   task automatic issue(input logic [1:0] id, input logic [7:0] d, input logic par, input logic b2b);
      exp_t e;
      e.id   = id;
      e.data = d;
      e.pen  = parity_en;
      e.s2   = stop2;
      e.par  = par;
      e.b2b  = b2b;
      e.div  = baud_div;
      exp_q.push_back(e);
      reqq[id].push_back(d);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         @(posedge PCLK);
         #1;
         n++;
      end
      chk("drain", 32'(exp_q.size()) * 2 + 32'(busy), 32'(0));
      #1;
   endtask

   task automatic wait_busy(input int budget);
      int n;
      n = 0;
      while (!busy && n < budget) begin
         @(posedge PCLK);
         #1;
         n++;
      end
      chk("busy_rise", 32'(busy), 32'(1));
   endtask

   initial begin
      PRESETn    = 1'b1;
      baud_div   = 16'd4;
      parity_en  = 1'b0;
      parity_odd = 1'b0;
      stop2      = 1'b0;
      #1 PRESETn = 1'b0;
      @(negedge PCLK);
      chk("rst_line", 32'({tx, busy, frame_done}), 32'(3'b100));
      chk("rst_ready", 32'(req_ready), 32'(0));
      chk("rst_gid", 32'(grant_id), 32'(0));
      @(posedge PCLK);
      #2 PRESETn = 1'b1;

      // Round robin, back-to-back 10-cycle frames
      @(posedge PCLK);
      #2;
      baud_div = 16'd1;
      issue(2'd0, 8'h11, 1'b0, 1'b0);
      issue(2'd1, 8'h22, 1'b0, 1'b1);
      issue(2'd2, 8'h33, 1'b0, 1'b1);
      issue(2'd3, 8'h44, 1'b0, 1'b1);
      issue(2'd0, 8'h55, 1'b0, 1'b1);
      drain(200);

      // Single frame 0xA5 at 4 cycles per bit
      baud_div = 16'd4;
      issue(2'd0, 8'hA5, 1'b0, 1'b0);
      drain(200);

      // Parity on 0x07: even -> 1, odd -> 0, then odd with two stop bits
      baud_div  = 16'd2;
      parity_en = 1'b1;
      issue(2'd1, 8'h07, 1'b1, 1'b0);
      drain(200);
      parity_odd = 1'b1;
      issue(2'd1, 8'h07, 1'b0, 1'b0);
      drain(200);
      stop2 = 1'b1;
      issue(2'd2, 8'h07, 1'b0, 1'b0);
      drain(200);
      parity_en  = 1'b0;
      parity_odd = 1'b0;
      stop2      = 1'b0;

      // Divisor 0 behaves as 1
      baud_div = 16'd0;
      issue(2'd3, 8'h3C, 1'b0, 1'b0);
      drain(200);

      // Divisor change mid-frame only applies to the next grant
      baud_div = 16'd4;
      issue(2'd0, 8'h96, 1'b0, 1'b0);
      wait_busy(50);
      #1;
      baud_div = 16'd8;
      issue(2'd1, 8'h69, 1'b0, 1'b1);
      drain(400);

      // Sparse requests: 2, idle gap, then 1 via pointer wrap
      baud_div = 16'd1;
      issue(2'd2, 8'h5A, 1'b0, 1'b0);
      drain(200);
      repeat (20) @(posedge PCLK);
      #2;
      issue(2'd1, 8'hC3, 1'b0, 1'b0);
      drain(200);

      // Reset during data bit 3 of 0xF0 (a 0 bit on the line)
      baud_div = 16'd4;
      issue(2'd0, 8'hF0, 1'b0, 1'b0);
      wait_busy(50);
      repeat (17) @(posedge PCLK);
      #2 PRESETn = 1'b0;
      #1;
      chk("rst_async_tx", 32'(tx), 32'(1));
      chk("rst_async_busy", 32'(busy), 32'(0));
      chk("rst_async_ready", 32'(req_ready), 32'(0));
      issue(2'd0, 8'h01, 1'b0, 1'b0);
      issue(2'd1, 8'h02, 1'b0, 1'b1);
      issue(2'd2, 8'h03, 1'b0, 1'b1);
      repeat (2) @(negedge PCLK);
      chk("rst_hold_ready", 32'(req_ready), 32'(0));
      chk("rst_hold_gid", 32'(grant_id), 32'(0));
      @(posedge PCLK);
      #2 PRESETn = 1'b1;
      drain(500);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
